// File: rtl/uart_tx_scheduler_if.sv
// UART TX handshake bundle between the scheduler and the transmitter.
// The scheduler is the master: it drives tx_start/tx_data, the UART answers with tx_busy.
interface uart_tx_scheduler_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX between hex count reports and RX echo bytes.
// Echo FIFO and round-robin arbitration exist only with UART_TX_SCHEDULER_ECHO_EN.
module uart_tx_scheduler #(
    parameter int ECHO_DEPTH = 4
) (
    input  logic                        clk_12m,
    input  logic                        rst_n,
    input  logic                        report_req,
    input  logic [15:0]                 report_value,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    uart_tx_scheduler_if.master         tx,
    output logic                        report_pending,
    output logic [$clog2(ECHO_DEPTH):0] echo_level,
    output logic [7:0]                  echo_drops,
    output logic                        sched_idle
);
    localparam int AW = $clog2(ECHO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        gnt_echo;
    logic        gnt_echo_nx;
    logic        last_echo;
    logic        last_echo_nx;
    logic [15:0] snap;
    logic [15:0] msg;
    logic [2:0]  idx;
    logic [7:0]  data_q;
    logic        echo_avail;
    logic [7:0]  echo_head;
    logic        pop;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] report_byte(
        input logic [15:0] v,
        input logic [2:0]  i
    );
        logic [7:0] b;
        case (i)
            3'd0:    b = hex_ascii(v[15:12]);
            3'd1:    b = hex_ascii(v[11:8]);
            3'd2:    b = hex_ascii(v[7:4]);
            3'd3:    b = hex_ascii(v[3:0]);
            3'd4:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    assign pop         = (state == LOAD) && gnt_echo;
    assign tx.tx_start = (state == START);
    assign tx.tx_data  = data_q;

    always_comb begin
        state_nx     = state;
        gnt_echo_nx  = gnt_echo;
        last_echo_nx = last_echo;
        case (state)
            IDLE: begin
                if (report_pending && echo_avail) begin
                    // tie: favour whoever lost the previous tie
                    gnt_echo_nx  = !last_echo;
                    last_echo_nx = !last_echo;
                    state_nx     = LOAD;
                end else if (report_pending) begin
                    gnt_echo_nx = 1'b0;
                    state_nx    = LOAD;
                end else if (echo_avail) begin
                    gnt_echo_nx = 1'b1;
                    state_nx    = LOAD;
                end
            end
            LOAD:     state_nx = START;
            START:    state_nx = WAIT_ACK;
            WAIT_ACK: state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (!tx.tx_busy) begin
                    if (!gnt_echo && (idx != 3'd5)) begin
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            gnt_echo       <= 1'b0;
            last_echo      <= 1'b1;
            snap           <= 16'h0000;
            msg            <= 16'h0000;
            idx            <= 3'd0;
            data_q         <= 8'h00;
            report_pending <= 1'b0;
            sched_idle     <= 1'b1;
        end else begin
            state      <= state_nx;
            gnt_echo   <= gnt_echo_nx;
            last_echo  <= last_echo_nx;
            sched_idle <= (state == IDLE) && !report_pending && !echo_avail;
            // a new request beats the clear so it waits for the next message
            if (report_req) begin
                snap           <= report_value;
                report_pending <= 1'b1;
            end else if ((state == LOAD) && !gnt_echo) begin
                report_pending <= 1'b0;
            end
            if (state == LOAD) begin
                if (gnt_echo) begin
                    data_q <= echo_head;
                end else begin
                    msg    <= snap;
                    idx    <= 3'd0;
                    data_q <= report_byte(snap, 3'd0);
                end
            end else if ((state == WAIT_DONE) && (state_nx == START)) begin
                idx    <= idx + 3'd1;
                data_q <= report_byte(msg, idx + 3'd1);
            end
        end
    end

`ifdef UART_TX_SCHEDULER_ECHO_EN
    logic [7:0]    mem [ECHO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    drops;
    logic          full;
    logic          push;
    logic          drop;

    assign full       = (count == (AW+1)'(ECHO_DEPTH));
    // a pop in the same cycle frees the slot the push needs
    assign push       = rx_valid && (!full || pop);
    assign drop       = rx_valid && full && !pop;
    assign echo_avail = (count != '0);
    assign echo_head  = mem[rd_ptr];
    assign echo_level = count;
    assign echo_drops = drops;

    always_ff @(posedge clk_12m) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drops  <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop && (drops != 8'hFF)) begin
                drops <= drops + 8'h01;
            end
        end
    end
`else
    logic unused_echo;

    assign echo_avail  = 1'b0;
    assign echo_head   = 8'h00;
    assign echo_level  = '0;
    assign echo_drops  = 8'h00;
    assign unused_echo = &{1'b0, rx_valid, rx_data, pop};
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected bytes,
// a negedge monitor pops them on every tx_start.
module tb_uart_tx_scheduler;
    localparam int DEPTH = 4;
`ifdef UART_TX_SCHEDULER_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic                     clk_12m = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     report_req = 1'b0;
    logic [15:0]              report_value = 16'h0;
    logic                     rx_valid = 1'b0;
    logic [7:0]               rx_data = 8'h0;
    logic                     report_pending;
    logic [$clog2(DEPTH):0]   echo_level;
    logic [7:0]               echo_drops;
    logic                     sched_idle;

    uart_tx_scheduler_if tx_if ();

    uart_tx_scheduler #(.ECHO_DEPTH(DEPTH)) dut (
        .clk_12m        (clk_12m),
        .rst_n          (rst_n),
        .report_req     (report_req),
        .report_value   (report_value),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .tx             (tx_if),
        .report_pending (report_pending),
        .echo_level     (echo_level),
        .echo_drops     (echo_drops),
        .sched_idle     (sched_idle)
    );

    always #5 clk_12m = ~clk_12m;

    int         tests = 0;
    int         fails = 0;
    int         n_start = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sent = 8'h00;
    bit         last_echo = 1'b1;
    int         busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    task automatic push_report(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(hexc((int'(v) >> (12 - 4 * i)) & 15));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // UART TX stand-in: busy from the cycle after tx_start for 2..10 cycles
    always @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            tx_if.tx_busy <= 1'b0;
            busy_cnt      <= 0;
        end else if (tx_if.tx_start) begin
            tx_if.tx_busy <= 1'b1;
            busy_cnt      <= $urandom_range(2, 10);
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt      <= 0;
            tx_if.tx_busy <= 1'b0;
        end
    end

    always @(negedge clk_12m) begin
        if (rst_n) begin
            if (tx_if.tx_start) begin
                n_start++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tx: got %0h expected no byte",
                             tx_if.tx_data);
                end else begin
                    sent = exp_q.pop_front();
                    check("tx_byte", {24'h0, tx_if.tx_data}, {24'h0, sent});
                end
            end else if (tx_if.tx_busy) begin
                check("tx_data_stable", {24'h0, tx_if.tx_data}, {24'h0, sent});
            end
        end
    end

    task automatic tick();
        @(negedge clk_12m);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        report_req = 1'b0;
        rx_valid   = 1'b0;
        exp_q.delete();
        last_echo  = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (k < 3000 &&
               !(exp_q.size() == 0 && sched_idle && !tx_if.tx_busy)) begin
            tick();
            k++;
        end
        tests++;
        if (k >= 3000) begin
            fails++;
            $display("FAIL %s_drain: got %0d bytes left expected 0",
                     name, exp_q.size());
        end
        repeat (3) tick();
        check({name, "_idle"}, {31'h0, sched_idle}, 32'h1);
        check({name, "_pending"}, {31'h0, report_pending}, 32'h0);
    endtask

    task automatic wait_starts(input int target);
        int k = 0;
        while (n_start < target && k < 2000) begin
            tick();
            k++;
        end
        tests++;
        if (k >= 2000) begin
            fails++;
            $display("FAIL wait_start: got %0d starts expected %0d",
                     n_start, target);
        end
    endtask

    task automatic send_report(input logic [15:0] v);
        push_report(v);
        report_value = v;
        report_req   = 1'b1;
        tick();
        report_req = 1'b0;
    endtask

    task automatic send_tie(input logic [15:0] v, input logic [7:0] b);
        if (!ECHO) begin
            push_report(v);
        end else if (last_echo) begin
            push_report(v);
            exp_q.push_back(b);
            last_echo = 1'b0;
        end else begin
            exp_q.push_back(b);
            push_report(v);
            last_echo = 1'b1;
        end
        report_value = v;
        report_req   = 1'b1;
        rx_data      = b;
        rx_valid     = 1'b1;
        tick();
        report_req = 1'b0;
        rx_valid   = 1'b0;
    endtask

    task automatic send_burst(input int k);
        for (int i = 0; i < k; i++) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
            if (ECHO) exp_q.push_back(rx_data);
            tick();
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit prev;
        repeat (2) tick();
        check("rst_tx_start", {31'h0, tx_if.tx_start}, 32'h0);
        check("rst_tx_data", {24'h0, tx_if.tx_data}, 32'h0);
        check("rst_pending", {31'h0, report_pending}, 32'h0);
        check("rst_level", {29'h0, echo_level}, 32'h0);
        check("rst_drops", {24'h0, echo_drops}, 32'h0);
        check("rst_idle", {31'h0, sched_idle}, 32'h1);
        rst_n = 1'b1;
        tick();

        // single report with latency
        push_report(16'h00A5);
        report_value = 16'h00A5;
        report_req   = 1'b1;
        tick();
        report_req = 1'b0;
        check("lat_c1_start", {31'h0, tx_if.tx_start}, 32'h0);
        check("lat_c1_pending", {31'h0, report_pending}, 32'h1);
        tick();
        check("lat_c2_start", {31'h0, tx_if.tx_start}, 32'h0);
        tick();
        check("lat_c3_start", {31'h0, tx_if.tx_start}, 32'h1);
        wait_drain("single");

        // coalescing
        base = n_start;
        send_report(16'h0001);
        wait_starts(base + 3);
        tick();
        report_value = 16'h0002;
        report_req   = 1'b1;
        tick();
        report_value = 16'h0003;
        tick();
        report_req = 1'b0;
        push_report(16'h0003);
        check("coal_pending", {31'h0, report_pending}, 32'h1);
        prev = 1'b1;
        for (int k = 0; k < 2000 && prev; k++) begin
            tick();
            prev = report_pending;
        end
        check("coal_clear_at_load", {31'h0, tx_if.tx_start}, 32'h1);
        wait_drain("coal");
        check("coal_msgs", n_start - base, 32'd12);

        // round-robin ties
        do_reset();
        send_tie(16'h1234, 8'h61);
        wait_drain("rr1");
        send_tie(16'($urandom), 8'($urandom));
        wait_drain("rr2");
        check("rr_level", {29'h0, echo_level}, 32'h0);

        // overflow while a report is in flight
        do_reset();
        base = n_start;
        send_report(16'($urandom));
        wait_starts(base + 1);
        for (int i = 0; i < 6; i++) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
            if (ECHO && i < 4) exp_q.push_back(rx_data);
            tick();
        end
        rx_valid = 1'b0;
        tick();
        check("ovf_level", {29'h0, echo_level}, ECHO ? 32'd4 : 32'd0);
        check("ovf_drops", {24'h0, echo_drops}, ECHO ? 32'd2 : 32'd0);
        wait_drain("ovf");
        check("ovf_drops_hold", {24'h0, echo_drops}, ECHO ? 32'd2 : 32'd0);

        // reset in the middle of a report
        base = n_start;
        send_report(16'($urandom));
        wait_starts(base + 3);
        #2 rst_n = 1'b0;
        exp_q.delete();
        last_echo = 1'b1;
        #1;
        check("mid_rst_start", {31'h0, tx_if.tx_start}, 32'h0);
        check("mid_rst_pending", {31'h0, report_pending}, 32'h0);
        check("mid_rst_idle", {31'h0, sched_idle}, 32'h1);
        check("mid_rst_data", {24'h0, tx_if.tx_data}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        base  = n_start;
        repeat (80) tick();
        check("mid_rst_silent", n_start - base, 32'd0);

        // randomized mix, each message set drained before the next
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0:       send_report(16'($urandom));
                1:       send_burst($urandom_range(1, DEPTH));
                default: send_tie(16'($urandom), 8'($urandom));
            endcase
            wait_drain("rand");
        end
        check("final_level", {29'h0, echo_level}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
